// File: rtl/write_combine_buffer_if.sv
// Store-side bus bundle for the write-combine buffer: CPU store port, flush
// handshake and the masked burst write port towards L2/arbiter.
interface write_combine_buffer_if;
    logic         cpu_write;
    logic [15:0]  cpu_address;
    logic [15:0]  cpu_wdata;
    logic [1:0]   cpu_byte_enable;
    logic         cpu_resp;
    logic         flush;
    logic         flush_done;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [31:0]  mem_byte_mask;
    logic         mem_resp;

    // The buffer itself.
    modport slave (
        input  cpu_write, cpu_address, cpu_wdata, cpu_byte_enable, flush, mem_resp,
        output cpu_resp, flush_done, mem_write, mem_address, mem_wdata, mem_byte_mask
    );

    // The CPU/memory environment around it.
    modport master (
        output cpu_write, cpu_address, cpu_wdata, cpu_byte_enable, flush, mem_resp,
        input  cpu_resp, flush_done, mem_write, mem_address, mem_wdata, mem_byte_mask
    );
endinterface

// File: rtl/write_combine_buffer.sv
// Single-line write-combine buffer: merges 16-bit CPU stores into a 256-bit
// line image with per-byte valid bits and drains it as one masked burst.
module write_combine_buffer (
    input logic                   clk,
    input logic                   rst,
    write_combine_buffer_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, FILLING, DRAIN} state_t;

    state_t       state_q, state_d;
    logic [10:0]  tag_q;
    logic [255:0] line_q, line_merged;
    logic [31:0]  mask_q, mask_merged;

    logic [3:0]   word_idx;
    logic         tag_hit;
    logic         do_merge, latch_tag, clear_line;
    logic         cpu_resp, mem_write;
    logic         unused_addr_bit;

    assign word_idx        = bus.cpu_address[4:1];
    assign tag_hit         = (bus.cpu_address[15:5] == tag_q);
    assign unused_addr_bit = bus.cpu_address[0];

    // Image of the line/mask as they would look after merging the current store.
    always_comb begin
        line_merged = line_q;
        mask_merged = mask_q;
        if (bus.cpu_byte_enable[0]) begin
            line_merged[{word_idx, 4'd0} +: 8] = bus.cpu_wdata[7:0];
            mask_merged[{word_idx, 1'b0}]      = 1'b1;
        end
        if (bus.cpu_byte_enable[1]) begin
            line_merged[{word_idx, 4'd8} +: 8] = bus.cpu_wdata[15:8];
            mask_merged[{word_idx, 1'b1}]      = 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cpu_resp   = 1'b0;
        mem_write  = 1'b0;
        do_merge   = 1'b0;
        latch_tag  = 1'b0;
        clear_line = 1'b0;
        case (state_q)
            EMPTY: begin
                if (bus.cpu_write) begin
                    cpu_resp  = 1'b1;
                    latch_tag = 1'b1;
                    do_merge  = 1'b1;
                    if (bus.cpu_byte_enable != 2'b00) state_d = FILLING;
                end
            end
            FILLING: begin
                // Flush wins over a store in the same cycle; the store stalls.
                if (bus.flush) begin
                    state_d = DRAIN;
                end else if (bus.cpu_write) begin
                    if (tag_hit) begin
                        cpu_resp = 1'b1;
                        do_merge = 1'b1;
                        if (&mask_merged) state_d = DRAIN;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                mem_write = 1'b1;
                if (bus.mem_resp) begin
                    clear_line = 1'b1;
                    state_d    = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            tag_q   <= '0;
            // NOTE: the line image is reset as well because it is visible on
            // mem_wdata in every state, not only while a burst is requested.
            line_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            if (latch_tag) tag_q <= bus.cpu_address[15:5];
            if (clear_line) begin
                line_q <= '0;
                mask_q <= '0;
            end else if (do_merge) begin
                line_q <= line_merged;
                mask_q <= mask_merged;
            end
        end
    end

    assign bus.cpu_resp      = cpu_resp;
    assign bus.mem_write     = mem_write;
    assign bus.flush_done    = bus.flush && (state_q == EMPTY);
    assign bus.mem_address   = {tag_q, 5'b0};
    assign bus.mem_wdata     = line_q;
    assign bus.mem_byte_mask = mask_q;
endmodule

// File: tb/tb_write_combine_buffer.sv
// Directed plus randomized bench for write_combine_buffer, checked against a
// byte-array reference model of the combining line.
module tb_write_combine_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    write_combine_buffer_if bus ();
    write_combine_buffer dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the buffered line as 32 bytes with a valid flag each.
    bit         model_known = 0;
    bit         m_holding   = 0;
    bit         m_draining  = 0;
    logic [10:0] m_tag      = '0;
    logic [7:0] m_bytes [32];
    bit         m_valid [32];
    logic       exp_resp_q  = 1'b0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < 32; b++) begin
            m_bytes[b] = 8'h00;
            m_valid[b] = 1'b0;
        end
    endtask

    task automatic model_store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        int w;
        w = int'(a[4:1]);
        if (be[0]) begin m_bytes[2*w]   = d[7:0];  m_valid[2*w]   = 1'b1; end
        if (be[1]) begin m_bytes[2*w+1] = d[15:8]; m_valid[2*w+1] = 1'b1; end
    endtask

    function automatic bit model_full();
        for (int b = 0; b < 32; b++) if (!m_valid[b]) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: apply inputs, check all outputs against the model, take the edge.
    task automatic tick(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] be, input logic f, input logic mr, input logic r);
        logic [255:0] e_data;
        logic [31:0]  e_mask;
        logic         e_resp;
        bus.cpu_write = w; bus.cpu_address = a; bus.cpu_wdata = d;
        bus.cpu_byte_enable = be; bus.flush = f; bus.mem_resp = mr; rst = r;
        #2;
        e_resp = 1'b0;
        if (model_known) begin
            for (int b = 0; b < 32; b++) begin
                e_data[8*b +: 8] = m_bytes[b];
                e_mask[b]        = m_valid[b];
            end
            if (m_draining)     e_resp = 1'b0;
            else if (!m_holding) e_resp = w;
            else                e_resp = w && !f && (a[15:5] == m_tag);
            chk("cpu_resp",      bus.cpu_resp,      e_resp);
            chk("flush_done",    bus.flush_done,    f && !m_holding && !m_draining);
            chk("mem_write",     bus.mem_write,     m_draining);
            chk("mem_address",   bus.mem_address,   {m_tag, 5'b0});
            chk("mem_wdata",     bus.mem_wdata,     e_data);
            chk("mem_byte_mask", bus.mem_byte_mask, e_mask);
        end
        exp_resp_q = e_resp;
        @(posedge clk);
        if (r) begin
            model_known = 1; m_holding = 0; m_draining = 0; m_tag = '0;
            model_clear();
        end else if (model_known) begin
            if (m_draining) begin
                if (mr) begin m_draining = 0; model_clear(); end
            end else if (!m_holding) begin
                if (w) begin
                    m_tag = a[15:5];
                    model_store(a, d, be);
                    m_holding = (be != 2'b00);
                end
            end else if (f) begin
                m_holding = 0; m_draining = 1;
            end else if (w) begin
                if (a[15:5] == m_tag) begin
                    model_store(a, d, be);
                    if (model_full()) begin m_holding = 0; m_draining = 1; end
                end else begin
                    m_holding = 0; m_draining = 1;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 16'h0, 16'h0, 2'b00, 0, 0, 0);
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        for (int n = 0; n < 40; n++) begin
            tick(1, a, d, be, 0, 0, 0);
            if (exp_resp_q) return;
        end
        vectors++;
        miscompares++;
        $error("FAIL store_timeout: observed no response expected cpu_resp for %h", a);
    endtask

    initial begin
        logic        pend;
        logic [15:0] p_addr, p_data;
        logic [1:0]  p_be;
        logic        r_f, r_mr, r_rst;
        logic [10:0] tags [3];

        model_clear();
        rst = 1'b1;
        bus.cpu_write = 0; bus.cpu_address = '0; bus.cpu_wdata = '0;
        bus.cpu_byte_enable = '0; bus.flush = 0; bus.mem_resp = 0;
        @(posedge clk); #1;

        // Reset held two cycles under random inputs.
        for (int k = 0; k < 2; k++)
            tick(1'($urandom), 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1);
        idle(1);
        chk("rst_mem_write", bus.mem_write, 1'b0);
        chk("rst_cpu_resp",  bus.cpu_resp, 1'b0);
        chk("rst_mask",      bus.mem_byte_mask, 32'h0);
        chk("rst_wdata",     bus.mem_wdata, 256'h0);
        chk("rst_address",   bus.mem_address, 16'h0);

        // Single store then flush.
        store(16'h1236, 16'hBEEF, 2'b11);
        tick(0, 16'h0, 16'h0, 2'b00, 1, 0, 0);
        chk("flush_mem_write", bus.mem_write, 1'b1);
        chk("flush_address",   bus.mem_address, 16'h1220);
        chk("flush_word11",    bus.mem_wdata[191:176], 16'hBEEF);
        chk("flush_mask",      bus.mem_byte_mask, 32'h00C0_0000);
        tick(0, 16'h0, 16'h0, 2'b00, 1, 1, 0);
        chk("flush_done_after", bus.flush_done, 1'b1);
        idle(1);

        // Byte merge into one word.
        store(16'h1000, 16'h00AA, 2'b01);
        store(16'h1000, 16'hBB00, 2'b10);
        tick(0, 16'h0, 16'h0, 2'b00, 1, 0, 0);
        chk("merge_word0", bus.mem_wdata[15:0], 16'hBBAA);
        chk("merge_mask",  bus.mem_byte_mask, 32'h0000_0003);
        tick(0, 16'h0, 16'h0, 2'b00, 1, 1, 0);
        idle(1);

        // Conflicting tag forces a drain; the store retries from EMPTY.
        store(16'h1000, 16'h1111, 2'b11);
        tick(1, 16'h2002, 16'h2222, 2'b11, 0, 0, 0);
        chk("conflict_stall",   exp_resp_q, 1'b0);
        chk("conflict_write",   bus.mem_write, 1'b1);
        chk("conflict_address", bus.mem_address, 16'h1000);
        tick(1, 16'h2002, 16'h2222, 2'b11, 0, 0, 0);
        tick(1, 16'h2002, 16'h2222, 2'b11, 0, 0, 0);
        tick(1, 16'h2002, 16'h2222, 2'b11, 0, 1, 0);
        chk("conflict_resp_next", bus.cpu_resp, 1'b1);
        tick(1, 16'h2002, 16'h2222, 2'b11, 0, 0, 0);
        tick(0, 16'h0, 16'h0, 2'b00, 1, 0, 0);
        chk("conflict2_address", bus.mem_address, 16'h2000);
        chk("conflict2_word1",   bus.mem_wdata[31:16], 16'h2222);
        chk("conflict2_mask",    bus.mem_byte_mask, 32'h0000_000C);
        tick(0, 16'h0, 16'h0, 2'b00, 1, 1, 0);
        idle(1);

        // Sixteen full-word stores fill the line and drain without flush.
        for (int i = 0; i < 16; i++) store(16'h3000 + 16'(2 * i), 16'($urandom), 2'b11);
        chk("auto_mem_write", bus.mem_write, 1'b1);
        chk("auto_mask",      bus.mem_byte_mask, 32'hFFFF_FFFF);
        tick(0, 16'h0, 16'h0, 2'b00, 0, 1, 0);
        idle(1);

        // Reset while a burst is outstanding.
        store(16'h4008, 16'h5A5A, 2'b11);
        tick(0, 16'h0, 16'h0, 2'b00, 1, 0, 0);
        chk("rstdrain_pre", bus.mem_write, 1'b1);
        tick(0, 16'h0, 16'h0, 2'b00, 0, 0, 1);
        chk("rstdrain_write", bus.mem_write, 1'b0);
        chk("rstdrain_mask",  bus.mem_byte_mask, 32'h0);
        tick(0, 16'h0, 16'h0, 2'b00, 1, 0, 0);
        chk("rstdrain_flush_done", bus.flush_done, 1'b1);
        chk("rstdrain_no_burst",   bus.mem_write, 1'b0);
        idle(1);

        // Randomized traffic: stores held until accepted, random flush,
        // mem_resp pulses (some outside DRAIN), occasional reset.
        tags[0] = 11'h055; tags[1] = 11'h2A1; tags[2] = 11'h7FF;
        pend = 0; p_addr = '0; p_data = '0; p_be = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend   = 1;
                p_addr = {tags[$urandom_range(0, 2)], 5'($urandom)};
                p_data = 16'($urandom);
                p_be   = 2'($urandom);
            end
            r_f   = ($urandom_range(0, 11) == 0);
            r_mr  = m_draining ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            r_rst = ($urandom_range(0, 299) == 0);
            tick(pend, p_addr, p_data, p_be, r_f, r_mr, r_rst);
            if (exp_resp_q || r_rst) pend = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/write_combine_buffer.md
Name: write_combine_buffer

Overview:
- Store-side counterpart of the line word selector: takes 16-bit CPU word/byte stores and merges each into a 256-bit line image at the offset-selected word lane.
- Holds one line and tracks per-byte valid bits.
- Drains the line to the next memory level as one masked burst write.
- Sits between the CPU data port store path and the L2/arbiter write port.

Parameters:
- none (widths fixed by lc3b_types: word 16, offset 5, burst 256)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_write  in  1  store request; held high until cpu_resp
- cpu_address  in  16  byte address; [15:5] line tag, [4:1] word index
- cpu_wdata  in  16  store data
- cpu_byte_enable  in  2  [0] low byte, [1] high byte
- cpu_resp  out  1  combinational; store accepted this cycle
- flush  in  1  level request to drain the buffer
- flush_done  out  1  combinational; high when flush=1 and state EMPTY
- mem_write  out  1  burst write request; held until mem_resp
- mem_address  out  16  {tag, 5'b0}
- mem_wdata  out  256  line image
- mem_byte_mask  out  32  per-byte valid; bit n covers mem_wdata[8n+7:8n]
- mem_resp  in  1  burst write complete (single-cycle pulse)

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- State: EMPTY, FILLING, DRAIN. Registers: tag[10:0], line[255:0], mask[31:0].
- Reset (any state, including mid-DRAIN): state EMPTY, tag=0, line=0, mask=0. Next cycle: mem_write=0, cpu_resp=0, flush_done per flush, mem_address=0, mem_wdata=0, mem_byte_mask=0.
- Merge rule, for word index i = cpu_address[4:1]:
  - be[0] writes line[16i+7:16i] from wdata[7:0] and sets mask[2i].
  - be[1] writes line[16i+15:16i+8] from wdata[15:8] and sets mask[2i+1].
  - Unenabled bytes are unchanged.
- EMPTY:
  - cpu_write=1: cpu_resp=1 same cycle; latch tag=cpu_address[15:5]; merge.
  - Go FILLING if be!=00; if be=00, respond and stay EMPTY.
  - flush alone: flush_done=1, stay EMPTY.
- FILLING:
  - flush=1 has priority: go DRAIN; cpu_resp=0 that cycle (store stalls).
  - Else cpu_write with tag match: cpu_resp=1, merge. If the resulting mask is all ones, go DRAIN next cycle; otherwise stay.
  - Else cpu_write with tag mismatch: cpu_resp=0, go DRAIN. The store is re-evaluated from EMPTY after the drain.
- DRAIN:
  - mem_write=1. mem_address, mem_wdata and mem_byte_mask are driven straight from registers and stay stable until mem_resp.
  - cpu_resp=0 throughout.
  - On mem_resp: clear line and mask to 0, go EMPTY. The pending cpu_write is accepted in the following cycle, not the mem_resp cycle.
- Latency:
  - Store hit/empty: 0 cycles (combinational resp, state at the edge).
  - Conflict store: drain time + 1 cycle.
- Outside DRAIN: mem_write=0; mem_address/mem_wdata/mem_byte_mask still reflect the registers.
- The buffer never drains with an all-zero mask.
- mem_resp outside DRAIN is ignored.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> mem_write=0, cpu_resp=0, mem_byte_mask=0, mem_wdata=0, mem_address=0.
- Single store then flush:
  - write 0x1236, data 0xBEEF, be=11 -> cpu_resp same cycle.
  - flush=1 -> next cycle mem_write=1, mem_address=0x1220, mem_wdata[191:176]=0xBEEF, mem_byte_mask=0x00C00000.
  - mem_resp -> next cycle flush_done=1.
- Byte merge:
  - write 0x1000, data 0x00AA, be=01; then write 0x1000, data 0xBB00, be=10.
  - flush -> mem_wdata[15:0]=0xBBAA, mem_byte_mask=0x00000003.
- Conflict:
  - buffer holds 0x1000 (word 0=0x1111); write 0x2002, data 0x2222, be=11 -> cpu_resp=0; mem_write with mem_address=0x1000.
  - mem_resp after 3 cycles -> one cycle later cpu_resp=1.
  - Later flush -> mem_address=0x2000, mem_wdata[31:16]=0x2222, mask=0x0000000C.
- Auto-drain: 16 full-word stores to 0x3000..0x301E -> mem_write=1 the cycle after the 16th resp, mem_byte_mask=0xFFFFFFFF, no flush needed.
- Reset mid-DRAIN: rst while mem_write=1 -> next cycle mem_write=0, mask=0; later flush -> flush_done=1 immediately, no burst issued.
